// File: rtl/rom_loader.sv
// rom_loader: turns a byte stream into word writes for a ROM-style memory.
// A start pulse opens a load session. Bytes are packed little-endian into
// DATA_WIDTH-bit words. Each completed word is written once through wr_en,
// wr_addr and wr_data, at addresses counting up from 0. The session ends on
// dl_last, or after the last memory address has been written.
//
// Parameters:
//   widthad_a  - write-address width; memory depth is 2^widthad_a words
//   DATA_WIDTH - word width, 8 or 16
//
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   start             - one-cycle session request (honoured in IDLE/DONE only)
//   dl_valid/dl_data/dl_last/dl_ready - byte-stream handshake
//   wr_en/wr_addr/wr_data             - one-cycle memory write
//   rd_ena_n          - active-low read enable, low only outside a session
//   busy, done, full  - session status levels
//   checksum          - modulo-256 sum of the accepted bytes
//                       (exists only when ROM_LOADER_CHECKSUM_EN is defined)
//
// Configuration macro: ROM_LOADER_CHECKSUM_EN adds the checksum output.
module rom_loader #(
  parameter int unsigned widthad_a  = 15,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dl_valid,
  input  logic [7:0]            dl_data,
  input  logic                  dl_last,
  output logic                  dl_ready,
  output logic                  wr_en,
  output logic [widthad_a-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_ena_n,
  output logic                  busy,
  output logic                  done,
  output logic                  full
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]            checksum
`endif
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [widthad_a-1:0] LAST_ADDR = '1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state;
  logic [widthad_a-1:0]  addr;
  logic [IDX_W-1:0]      byte_idx;
  logic [DATA_WIDTH-1:0] word_buf;
  logic                  last_seen;

  logic                  accept_c;
  logic [DATA_WIDTH-1:0] word_next_c;

  // dl_ready is only ever high in COLLECT, so this is the whole handshake.
  assign accept_c = dl_valid && dl_ready;

  // Current word with the incoming byte dropped into its lane. The buffer
  // is cleared at the start of every word, so unfilled lanes read as 0x00.
  always_comb begin
    word_next_c = word_buf;
    for (int i = 0; i < int'(BYTES); i++) begin
      if (byte_idx == IDX_W'(i)) begin
        word_next_c[i*8 +: 8] = dl_data;
      end
    end
  end

  // Session FSM; every status output is a register updated with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      last_seen <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      dl_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      full      <= 1'b0;
      rd_ena_n  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= COLLECT;
            addr      <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            last_seen <= 1'b0;
            done      <= 1'b0;
            full      <= 1'b0;
            dl_ready  <= 1'b1;
            busy      <= 1'b1;
            rd_ena_n  <= 1'b1;
          end
        end

        COLLECT: begin
          if (accept_c) begin
            if (byte_idx == LAST_IDX || dl_last) begin
              // Word complete (or cut short by dl_last): present it for one cycle.
              state     <= WRITE;
              dl_ready  <= 1'b0;
              wr_en     <= 1'b1;
              wr_addr   <= addr;
              wr_data   <= word_next_c;
              last_seen <= dl_last;
            end else begin
              word_buf <= word_next_c;
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end

        WRITE: begin
          if (last_seen || addr == LAST_ADDR) begin
            // Address never wraps: the top address ends the session as full,
            // even when it also carried dl_last.
            state    <= DONE;
            done     <= 1'b1;
            full     <= (addr == LAST_ADDR);
            busy     <= 1'b0;
            rd_ena_n <= 1'b0;
          end else begin
            state    <= COLLECT;
            addr     <= addr + widthad_a'(1);
            byte_idx <= '0;
            word_buf <= '0;
            dl_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // Running sum of accepted bytes only; pad bytes never pass the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      checksum <= '0;
    end else if ((state == IDLE || state == DONE) && start) begin
      checksum <= '0;
    end else if (accept_c) begin
      checksum <= checksum + dl_data;
    end
  end
`endif

endmodule
